// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/stall FSM with sequential and
// PC-relative redirect, sticky overflow flag and saturating redirect counter.
module pc_sequencer #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 8,
  parameter int STEP   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BUSYWAIT,
  input  logic                    JUMP,
  input  logic [1:0]              BRANCH,
  input  logic                    ZERO,
  input  logic signed [OFF_W-1:0] OFFSET,
  output logic [ADDR_W-1:0]       PC,
  output logic [ADDR_W-1:0]       PC_SEQ,
  output logic                    TAKEN,
  output logic                    WRAP,
  output logic [CNT_W-1:0]        TAKEN_CNT,
  output logic [1:0]              STATE
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  state_t state;
  state_t state_nxt;
  logic   update;

  logic [ADDR_W:0]          seq_sum;
  logic [ADDR_W:0]          tgt_sum;
  logic signed [ADDR_W-1:0] off_ext;
  logic signed [ADDR_W-1:0] delta;
  logic [ADDR_W-1:0]        pc_nxt;
  logic                     tgt_wrap;
  logic                     wrap_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign TAKEN = JUMP | ((BRANCH == 2'b01) & ZERO) | ((BRANCH == 2'b10) & ~ZERO);

  always_comb begin
    seq_sum = {1'b0, PC} + {1'b0, STEP_W};
    off_ext = ADDR_W'(OFFSET);
    delta   = off_ext * $signed(STEP_W);
    tgt_sum = {1'b0, seq_sum[ADDR_W-1:0]} + {1'b0, delta};
    // A negative delta wraps below zero exactly when the unsigned add does not carry
    tgt_wrap = off_ext[ADDR_W-1] ? ~tgt_sum[ADDR_W] : tgt_sum[ADDR_W];
    pc_nxt   = TAKEN ? tgt_sum[ADDR_W-1:0] : seq_sum[ADDR_W-1:0];
    wrap_hit = seq_sum[ADDR_W] | (TAKEN & tgt_wrap);
  end

  assign PC_SEQ = seq_sum[ADDR_W-1:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = BUSYWAIT ? STALL : RUN;
      STALL:   state_nxt = BUSYWAIT ? STALL : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    STATE  = state;
    update = ((state == RUN) || (state == STALL)) && !BUSYWAIT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC        <= '0;
      WRAP      <= 1'b0;
      TAKEN_CNT <= '0;
    end else if (update) begin
      PC <= pc_nxt;
      if (wrap_hit) WRAP <= 1'b1;
      if (TAKEN) TAKEN_CNT <= sat_inc(TAKEN_CNT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all
// checked against an arithmetic reference model of the fetch sequence.
module tb_pc_sequencer;

  localparam longint M = 64'h1_0000_0000;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              BUSYWAIT = 1'b0;
  logic              JUMP = 1'b0;
  logic [1:0]        BRANCH = 2'b00;
  logic              ZERO = 1'b0;
  logic signed [7:0] OFFSET = 8'sd0;

  logic [31:0] pc, pc_seq, pc2, pc_seq2;
  logic        taken, wrap, taken2, wrap2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  logic [1:0]  state, state2;

  int n_cmp = 0;
  int n_err = 0;

  longint m_pc;
  int     m_state;
  bit     m_wrap;
  longint m_cnt;
  longint m_cnt2;

  pc_sequencer dut (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .PC(pc), .PC_SEQ(pc_seq), .TAKEN(taken),
    .WRAP(wrap), .TAKEN_CNT(cnt), .STATE(state)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .PC(pc2), .PC_SEQ(pc_seq2), .TAKEN(taken2),
    .WRAP(wrap2), .TAKEN_CNT(cnt2), .STATE(state2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit bw, input bit j, input logic [1:0] br, input bit z,
                       input logic signed [7:0] off);
    bit     tk, upd, w;
    longint seq, t;
    BUSYWAIT = bw; JUMP = j; BRANCH = br; ZERO = z; OFFSET = off;
    #1;
    tk = j || (br == 2'd1 && z) || (br == 2'd2 && !z);
    chk("taken", {63'd0, taken}, {63'd0, tk});
    chk("pc_seq", {32'd0, pc_seq}, (m_pc + 4) % M);
    upd = (m_state != 0) && !bw;
    if (m_state == 0) m_state = 1;
    else m_state = bw ? 2 : 1;
    if (upd) begin
      seq = m_pc + 4;
      w = (seq >= M);
      seq = seq % M;
      if (tk) begin
        t = seq + longint'(off) * 4;
        if (t < 0 || t >= M) w = 1;
        m_pc = ((t % M) + M) % M;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else begin
        m_pc = seq;
      end
      if (w) m_wrap = 1;
    end
    @(posedge CLK);
    #1;
    chk("pc", {32'd0, pc}, m_pc);
    chk("pc_cnt2dut", {32'd0, pc2}, m_pc);
    chk("state", {62'd0, state}, longint'(m_state));
    chk("wrap", {63'd0, wrap}, {63'd0, m_wrap});
    chk("taken_cnt", {48'd0, cnt}, m_cnt);
    chk("taken_cnt_w2", {62'd0, cnt2}, m_cnt2);
    @(negedge CLK);
  endtask

  task automatic goto(input longint target);
    longint d;
    d = target - m_pc - 4;
    if (d > M / 2) d -= M;
    if (d < -(M / 2)) d += M;
    cycle(0, 1, 2'b00, 0, 8'(d / 4));
    chk("goto_pc", {32'd0, pc}, target);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_wrap", {63'd0, wrap}, 64'd0);
    chk("rst_cnt", {48'd0, cnt}, 64'd0);
    chk("rst_pc_seq", {32'd0, pc_seq}, 64'd4);
    m_pc = 0; m_state = 0; m_wrap = 0; m_cnt = 0; m_cnt2 = 0;
    @(posedge CLK);
    #1;
    chk("rst_hold_pc", {32'd0, pc}, 64'd0);
    chk("rst_hold_state", {62'd0, state}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Boot then straight-line fetch
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 2'b00, 0, 8'sd0);
      chk("boot_seq_pc", {32'd0, pc}, longint'(i * 4));
      chk("boot_seq_state", {62'd0, state}, 64'd1);
    end

    // Narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 2'b00, 0, 8'sd0);
      chk("sat_cnt2", {62'd0, cnt2}, (i < 3) ? longint'(i + 1) : 64'd3);
    end

    goto(64'h10);
    cycle(0, 0, 2'b01, 1, -8'sd2);
    chk("beqz_taken_pc", {32'd0, pc}, 64'h0C);
    goto(64'h10);
    cycle(0, 0, 2'b01, 0, -8'sd2);
    chk("beqz_fall_pc", {32'd0, pc}, 64'h14);
    cycle(0, 0, 2'b11, 1, 8'sd5);
    chk("reserved_branch_pc", {32'd0, pc}, 64'h18);
    cycle(0, 0, 2'b10, 0, 8'sd3);
    chk("bnez_taken_pc", {32'd0, pc}, 64'h28);

    // Stalled jump commits once on release
    goto(64'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 2'b00, 0, 8'sd2);
      chk("stall_pc", {32'd0, pc}, 64'h20);
      chk("stall_state", {62'd0, state}, 64'd2);
    end
    cycle(0, 1, 2'b00, 0, 8'sd2);
    chk("stall_release_pc", {32'd0, pc}, 64'h2C);
    cycle(0, 0, 2'b00, 0, 8'sd0);

    // Address overflow is sticky
    goto(64'hFFFF_FFFC);
    cycle(0, 0, 2'b00, 0, 8'sd0);
    chk("wrap_pc", {32'd0, pc}, 64'd0);
    chk("wrap_set", {63'd0, wrap}, 64'd1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, 0, 8'sd0);
    chk("wrap_sticky", {63'd0, wrap}, 64'd1);

    // Asynchronous reset in the middle of a stall
    goto(64'h40);
    cycle(1, 1, 2'b00, 0, 8'sd7);
    chk("pre_rst_state", {62'd0, state}, 64'd2);
    #2;
    do_reset();

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
